// File: rtl/vector_reverse_stream.sv
`default_nettype none
// ============================================================================
// Module      : vector_reverse_stream
// Description : Streaming per-word bit/byte reverser with a 2-entry output
//               queue; optional stored parity enabled by VREV_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_reverse_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef VREV_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [1:0] c_mode_pass     = 2'd0;
    localparam logic [1:0] c_mode_bit_rev  = 2'd1;
    localparam logic [1:0] c_mode_byte_swp = 2'd2;

    logic [WIDTH-1:0] w_bit_rev;
    logic [WIDTH-1:0] w_byte_swap;
    logic [WIDTH-1:0] w_byte_rev;
    logic [WIDTH-1:0] w_xform;

    genvar gi, gk;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_bit_rev[gi] = in_data[WIDTH-1-gi];
        end

        if (WIDTH % 8 == 0) begin : g_bytes
            localparam int NB = WIDTH / 8;
            for (gk = 0; gk < NB; gk++) begin : g_byte
                assign w_byte_swap[gk*8 +: 8] = in_data[(NB-1-gk)*8 +: 8];
                for (gi = 0; gi < 8; gi++) begin : g_byte_bit
                    assign w_byte_rev[gk*8+gi] = in_data[gk*8+7-gi];
                end
            end
        end else begin : g_no_bytes
            // Byte modes are meaningless without whole bytes; fall back to full reverse.
            assign w_byte_swap = w_bit_rev;
            assign w_byte_rev  = w_bit_rev;
        end
    endgenerate

    always_comb begin
        w_xform = in_data;
        case (in_mode)
            c_mode_pass:     w_xform = in_data;
            c_mode_bit_rev:  w_xform = w_bit_rev;
            c_mode_byte_swp: w_xform = w_byte_swap;
            default:         w_xform = w_byte_rev;
        endcase
    end

    logic [WIDTH-1:0] r_mem [2];
    logic             r_head;
    logic [1:0]       r_count;
    logic             r_live;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic             w_push;
    logic             w_pop;
    logic             w_tail;

    assign in_ready  = r_live && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_head];
    assign xfer_cnt  = r_xfer_cnt;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // Tail sits at head when empty and at the other slot when one entry is held.
    assign w_tail    = r_head ^ r_count[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_live     <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_mem[w_tail] <= w_xform;
            end
            if (w_pop) begin
                r_head     <= ~r_head;
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef VREV_PARITY_EN
    logic r_par [2];

    assign out_parity = r_par[r_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par[0] <= 1'b0;
            r_par[1] <= 1'b0;
        end else if (w_push) begin
            r_par[w_tail] <= ^w_xform;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_reverse_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_reverse_stream
// Description : Directed self-checking bench for vector_reverse_stream
//               (8-bit and 16-bit instances; parity checks with VREV_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_reverse_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_data8, out_data8;
    logic [1:0]  in_mode8;
    logic [15:0] xfer_cnt8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] in_data16, out_data16;
    logic [1:0]  in_mode16;
    logic [15:0] xfer_cnt16;

`ifdef VREV_PARITY_EN
    logic        out_parity8;
    logic        out_parity16;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_reverse_stream #(.WIDTH(8), .CNT_W(16)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_mode   (in_mode8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .xfer_cnt  (xfer_cnt8)
`ifdef VREV_PARITY_EN
        ,
        .out_parity(out_parity8)
`endif
    );

    vector_reverse_stream #(.WIDTH(16), .CNT_W(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .in_mode   (in_mode16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .xfer_cnt  (xfer_cnt16)
`ifdef VREV_PARITY_EN
        ,
        .out_parity(out_parity16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref16(input logic [15:0] d, input logic [1:0] m);
        logic [15:0] r;
        r = d;
        case (m)
            2'd1: for (int i = 0; i < 16; i++) r[i] = d[15-i];
            2'd2: r = {d[7:0], d[15:8]};
            2'd3: for (int b = 0; b < 2; b++)
                      for (int j = 0; j < 8; j++) r[b*8+j] = d[b*8+7-j];
            default: r = d;
        endcase
        return r;
    endfunction

    initial begin
        logic [15:0] rd;
        logic [1:0]  rm;

        in_valid8 = 0; in_data8 = '0; in_mode8 = '0; out_ready8 = 0;
        in_valid16 = 0; in_data16 = '0; in_mode16 = '0; out_ready16 = 0;

        // Reset state
        #3;
        check("rst_in_ready8",   in_ready8,   0);
        check("rst_out_valid8",  out_valid8,  0);
        check("rst_out_data16",  out_data16,  0);
        check("rst_xfer_cnt16",  xfer_cnt16,  0);
        #19 rst_n = 1'b1;
        #1;
        check("release_in_ready16_before_clk", in_ready16, 0);
        step();
        check("in_ready8_after_clk",  in_ready8,  1);
        check("in_ready16_after_clk", in_ready16, 1);

        // 8-bit full bit reverse
        in_valid8 = 1; in_data8 = 8'b1101_0010; in_mode8 = 2'd1; out_ready8 = 1;
        step();
        in_valid8 = 0;
        check("w8_mode1_valid", out_valid8, 1);
        check("w8_mode1_data",  out_data8,  8'b0100_1011);
        step();
        check("w8_xfer_cnt", xfer_cnt8, 1);
        check("w8_empty",    out_valid8, 0);

        in_valid8 = 1; in_data8 = 8'h07; in_mode8 = 2'd1;
        step();
        in_valid8 = 0;
        check("w8_07_data", out_data8, 8'hE0);
`ifdef VREV_PARITY_EN
        check("w8_07_parity", out_parity8, 1);
`endif
        step();
        check("w8_xfer_cnt2", xfer_cnt8, 2);

        // 16-bit modes on A1B2
        out_ready16 = 1;
        in_valid16 = 1; in_data16 = 16'hA1B2; in_mode16 = 2'd2;
        step();
        in_valid16 = 0;
        check("w16_mode2", out_data16, 16'hB2A1);
        step();
        in_valid16 = 1; in_mode16 = 2'd3;
        step();
        in_valid16 = 0;
        check("w16_mode3", out_data16, 16'h854D);
        step();
        in_valid16 = 1; in_mode16 = 2'd0;
        step();
        in_valid16 = 0;
        check("w16_mode0", out_data16, 16'hA1B2);
        step();
        check("w16_xfer_cnt3", xfer_cnt16, 3);

        // Backpressure: three words with consumer stalled
        out_ready16 = 0;
        in_valid16 = 1; in_mode16 = 2'd0; in_data16 = 16'h1111;
        step();
        check("bp_ready_after1", in_ready16, 1);
        in_data16 = 16'h2222;
        step();
        check("bp_ready_full", in_ready16, 0);
        check("bp_head_w0",    out_data16, 16'h1111);
        in_data16 = 16'h3333;
        step();
        check("bp_still_full", in_ready16, 0);
        check("bp_head_hold",  out_data16, 16'h1111);
        out_ready16 = 1;
        step();
        check("bp_head_w1",     out_data16, 16'h2222);
        check("bp_slot_freed",  in_ready16, 1);
        step();
        in_valid16 = 0;
        check("bp_head_w2",  out_data16, 16'h3333);
        check("bp_valid_w2", out_valid16, 1);
        step();
        check("bp_drained",  out_valid16, 0);
        check("bp_xfer_cnt", xfer_cnt16, 6);

        // Continuous stream of random words, one output per cycle
        out_ready16 = 1;
        for (int i = 0; i < 6; i++) begin
            rd = 16'($urandom);
            rm = 2'($urandom_range(0, 3));
            in_valid16 = 1; in_data16 = rd; in_mode16 = rm;
            step();
            check("stream_valid", out_valid16, 1);
            check("stream_data",  out_data16,  ref16(rd, rm));
        end
        in_valid16 = 0;
        step();
        check("stream_drained",  out_valid16, 0);
        check("stream_xfer_cnt", xfer_cnt16, 12);

        // Reset with two words queued
        out_ready16 = 0;
        in_valid16 = 1; in_data16 = 16'hBEEF; in_mode16 = 2'd1;
        step();
        in_data16 = 16'hCAFE;
        step();
        in_valid16 = 0;
        check("mid_full", in_ready16, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    out_valid16, 0);
        check("mid_rst_xfer_cnt", xfer_cnt16, 0);
        check("mid_rst_in_ready", in_ready16, 0);
        step();
        #1 rst_n = 1'b1;
        out_ready16 = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_output", out_valid16, 0);
        end
        check("post_rst_xfer_cnt", xfer_cnt16, 0);
        check("post_rst_in_ready", in_ready16, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
